jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of JK flip-flops between N_REQ requesters.
- Each requester presents per-bit J/K command vectors. The arbiter grants one requester at a time, latches its command and applies standard JK semantics to every bit of the bank.
- Sits between control agents and a shared status/flag register. It is the sequencing layer for the single-bit JK flip-flop with synchronous reset.

Parameters:
- WIDTH, 8, bits in the shared JK bank.
- N_REQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- lock  input  N_REQ  per-requester hold-bus request, sampled in APPLY.
- cmd_j  input  N_REQ*WIDTH  J vectors; requester i uses bits [i*WIDTH +: WIDTH].
- cmd_k  input  N_REQ*WIDTH  K vectors, same packing.
- gnt  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-cycle pulse: requester's command was applied.
- q  output  WIDTH  current bank contents.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high on clk. When rst=1 at a rising edge: q=0, gnt=0, ack=0, busy=0, state=IDLE, rr_ptr=0, latched command=0.
  - rst overrides everything, including an operation in flight; an aborted operation produces no ack and leaves q=0.
- Per-bit JK rule at apply (jl/kl = latched values): 00 hold, 01 clear, 10 set, 11 toggle.
- States: IDLE, GRANT, APPLY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set req bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Next cycle: gnt=onehot(w), latch cmd_j/cmd_k slice of w, go to GRANT.
- GRANT: one cycle; the command is already latched. Go to APPLY.
- APPLY:
  - On this edge, q is updated using the latched command and ack[w] pulses high for exactly one cycle, the cycle after the edge.
  - If lock[w]=1: stay granted, re-latch w's current cmd slice, go to GRANT. rr_ptr unchanged.
  - Else: gnt=0, rr_ptr=(w+1) mod N_REQ, go to IDLE.
- Latency: req high in IDLE at edge n gives gnt at n+1, q update and ack at n+3. Unlocked throughput is one command per 3 cycles; locked throughput is one per 2.
- Command capture:
  - The command is captured only when entering GRANT.
  - Changes to cmd_j/cmd_k after capture are ignored.
  - Deasserting req after grant does not cancel the operation; it still applies and acks.
- Fairness: a requester that keeps req high is served again only after every other pending requester has been served once, unless it holds lock.
- gnt is always one-hot or zero. ack is always one-hot or zero and never coincides with a different requester's gnt bit.
- busy = (state != IDLE).
- Requesters driving req with an all-zero J/K command still receive gnt and ack; q is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0. After release, the first grant goes to requester 0.
- JK truth table: requester 1 alone, sequence cmd_j/cmd_k = FF/00, 00/0F, 00/00, F0/F0 -> q = FF, F0, F0, 00. Each ack[1] arrives 3 cycles after its req and lasts one cycle.
- Round robin: req=4'b1111 held with distinct commands -> grant order 0,1,2,3,0. Each acked once per rotation; gnt never overlaps.
- Lock: requester 2 with lock=1 for 3 operations while req[0] is also high. Toggle command J=K=01 -> q bit0 toggles 3 times. Grant stays on 2, with 2-cycle spacing between ack[2] pulses; then lock=0 -> next grant goes to requester 3 if pending, else 0.
- Late changes: requester 3 issues J=0x55, then drops req and changes cmd_j to 0xAA in GRANT -> q becomes 0x55 and ack[3] still fires.
- Reset mid-operation: rst=1 during APPLY of a set-all command -> no ack, q=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sharing one JK flip-flop bank between requesters
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   cmd_j,
    input  logic [N_REQ*WIDTH-1:0]   cmd_k,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         q,
    output logic                     busy
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, APPLY} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, cur, win, nxt_ptr;
    logic              found;
    logic [WIDTH-1:0]  jl, kl;
    int                idx;

    // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign nxt_ptr = (cur == PW'(N_REQ - 1)) ? '0 : cur + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   state_nxt = APPLY;
            APPLY:   state_nxt = lock[cur] ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A locked owner keeps gnt and has its current command re-captured for the next apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            gnt    <= '0;
            ack    <= '0;
            rr_ptr <= '0;
            cur    <= '0;
            jl     <= '0;
            kl     <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur <= win;
                        gnt <= ONE << win;
                        jl  <= cmd_j[win*WIDTH +: WIDTH];
                        kl  <= cmd_k[win*WIDTH +: WIDTH];
                    end
                end
                APPLY: begin
                    q   <= (jl & ~q) | (~kl & q);
                    ack <= ONE << cur;
                    if (lock[cur]) begin
                        jl <= cmd_j[cur*WIDTH +: WIDTH];
                        kl <= cmd_k[cur*WIDTH +: WIDTH];
                    end else begin
                        gnt    <= '0;
                        rr_ptr <= nxt_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
